blink_sequencer: RTL and testbench
==================================

// Module: blink_sequencer
// PURPOSE
//   Sequences a programmable clock divider through a table of blink steps.
//   Each step holds a divide period, a high-phase count and a repeat count.
//   The block loads the divider, enables it and counts its period-wrap pulses.
//   It then advances to the next step, and either loops or stops.
//   Sits between the host/strap logic and the divider that drives out1/LEDs.
// PARAMETERS
//   STEP_BITS    2   log2 of table depth (2**STEP_BITS entries)
//   DIVIDE_BITS  7   width of divider period/high fields
//   REP_BITS     4   width of per-step repeat count
// PORTS
//   clk         in   1            system clock
//   rst         in   1            async reset, active-high
//   start       in   1            1-cycle pulse: begin sequence at step 0
//   stop        in   1            1-cycle pulse: abort, return to IDLE
//   loop_en     in   1            1: wrap from last_step to step 0; 0: finish
//   last_step   in   STEP_BITS    index of final active step
//   wr_en       in   1            table write strobe
//   wr_addr     in   STEP_BITS    table entry written
//   wr_period   in   DIVIDE_BITS  divide period for entry
//   wr_high     in   DIVIDE_BITS  high-phase (clear) count for entry
//   wr_reps     in   REP_BITS     repeat count for entry (0 treated as 1)
//   div_wrap    in   1            1-cycle pulse from divider at period end
//   div_enable  out  1            divider enable
//   div_load    out  1            1-cycle pulse: divider latches period/high
//   div_period  out  DIVIDE_BITS  period of current step
//   div_high    out  DIVIDE_BITS  high count of current step
//   step        out  STEP_BITS    current step index
//   busy        out  1            high in LOAD or RUN
//   done        out  1            high in DONE
// BEHAVIOUR
//   Reset: state=IDLE. All outputs are 0, and table entries are 0.
//   Table: wr_en writes an entry on the clock edge, in any state.
//     A write takes effect at the next LOAD of that entry.
//     A write to the current step does not alter div_period/div_high mid-RUN.
//   FSM states: IDLE, LOAD, RUN, DONE.
//   Priority: stop > start > div_wrap.
//   IDLE: on start -> LOAD with step=0 and rep_cnt=0.
//   LOAD: one cycle.
//     div_load=1, div_enable=0.
//     div_period/div_high are registered from table[step].
//     Next state: RUN.
//   RUN: div_enable=1. On each div_wrap:
//     - rep_cnt < reps-1: rep_cnt++ and stay in RUN.
//     - step < last_step: step++, rep_cnt=0 -> LOAD.
//     - step == last_step, loop_en=1: step=0 -> LOAD.
//     - step == last_step, loop_en=0: -> DONE.
//   DONE: div_enable=0, done=1. step holds last_step. start -> LOAD step 0.
//   stop: from any state, the next cycle is IDLE with div_enable=0 and step=0.
//   start in LOAD/RUN: restarts at step 0 via LOAD. rep_cnt is cleared.
//   Latency:
//     - start to div_load: 1 clk.
//     - div_load to div_enable: 1 clk.
//     - last div_wrap of a step to the next div_load: 1 clk.
//   last_step and loop_en are sampled at each step-advance decision.
//     Changing them mid-RUN is legal.
//   step never exceeds last_step.
//     If last_step is lowered below step, the next advance goes to step 0
//     (loop_en=1) or to DONE (loop_en=0).
//   div_wrap outside RUN is ignored.
//   Async reset mid-operation: immediate return to reset values.
// TESTING
//   1 Reset: rst=1 for 100 ns -> all outputs 0, state IDLE.
//   2 Single pass:
//     - table[0]={100,50,2}, table[1]={20,10,1}, last_step=1, loop_en=0.
//     - Pulse start.
//     - Expect: div_load with period 100; 2 wraps; div_load with period 20;
//       1 wrap; done=1; div_enable=0.
//   3 Loop:
//     - Same table, loop_en=1.
//     - Expect step sequence 0,0,1,0,0,1..., with busy constant 1.
//   4 Stop mid-RUN at step 1 -> next cycle IDLE, div_enable=0, step=0.
//     start and stop in the same cycle -> IDLE.
//   5 reps=0 entry behaves as reps=1, giving one wrap per step.
//     div_wrap pulses in IDLE/DONE produce no state change.
//   6 Write table[1] during RUN of step 1: div_period is unchanged until the
//     next LOAD of step 1, then shows the new value.

Source files
------------

// File: rtl/blink_sequencer.sv
// Steps a programmable clock divider through a small table of blink steps
// (period, high count, repeats), looping or stopping after the last step.
module blink_sequencer #(
  parameter int STEP_BITS   = 2,
  parameter int DIVIDE_BITS = 7,
  parameter int REP_BITS    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop_en,
  input  logic [STEP_BITS-1:0]   last_step,
  input  logic                   wr_en,
  input  logic [STEP_BITS-1:0]   wr_addr,
  input  logic [DIVIDE_BITS-1:0] wr_period,
  input  logic [DIVIDE_BITS-1:0] wr_high,
  input  logic [REP_BITS-1:0]    wr_reps,
  input  logic                   div_wrap,
  output logic                   div_enable,
  output logic                   div_load,
  output logic [DIVIDE_BITS-1:0] div_period,
  output logic [DIVIDE_BITS-1:0] div_high,
  output logic [STEP_BITS-1:0]   step,
  output logic                   busy,
  output logic                   done
);

  localparam int DEPTH = 2 ** STEP_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state_r;
  logic [DIVIDE_BITS-1:0] period_tbl_r [DEPTH];
  logic [DIVIDE_BITS-1:0] high_tbl_r   [DEPTH];
  logic [REP_BITS-1:0]    reps_tbl_r   [DEPTH];
  logic [REP_BITS-1:0]    reps_r;
  logic [REP_BITS-1:0]    rep_cnt_r;

  logic                   more_reps_s;
  logic                   load_s;
  logic                   finish_s;
  logic [STEP_BITS-1:0]   load_step_s;

  // Step table write port, usable in any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        period_tbl_r[i] <= '0;
        high_tbl_r[i]   <= '0;
        reps_tbl_r[i]   <= '0;
      end
    end else if (wr_en) begin
      period_tbl_r[wr_addr] <= wr_period;
      high_tbl_r[wr_addr]   <= wr_high;
      reps_tbl_r[wr_addr]   <= wr_reps;
    end else begin
      period_tbl_r[wr_addr] <= period_tbl_r[wr_addr];
    end
  end

  // Decide whether this cycle enters LOAD (and for which step) or finishes.
  always_comb begin
    more_reps_s = (rep_cnt_r < (reps_r - {{(REP_BITS-1){1'b0}}, 1'b1}));
    load_s      = 1'b0;
    finish_s    = 1'b0;
    load_step_s = '0;
    if (start) begin
      load_s = 1'b1;
    end else if (state_r == RUN && div_wrap && !more_reps_s) begin
      // A step above a lowered last_step falls through to wrap/finish.
      if (step < last_step) begin
        load_s      = 1'b1;
        load_step_s = step + {{(STEP_BITS-1){1'b0}}, 1'b1};
      end else if (loop_en) begin
        load_s = 1'b1;
      end else begin
        finish_s = 1'b1;
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // Sequencer FSM with registered divider controls and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      step       <= '0;
      rep_cnt_r  <= '0;
      reps_r     <= '0;
      div_enable <= 1'b0;
      div_load   <= 1'b0;
      div_period <= '0;
      div_high   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (stop) begin
      state_r    <= IDLE;
      step       <= '0;
      rep_cnt_r  <= '0;
      div_enable <= 1'b0;
      div_load   <= 1'b0;
      div_period <= '0;
      div_high   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (load_s) begin
      state_r    <= LOAD;
      step       <= load_step_s;
      rep_cnt_r  <= '0;
      reps_r     <= (reps_tbl_r[load_step_s] == '0) ? {{(REP_BITS-1){1'b0}}, 1'b1}
                                                    : reps_tbl_r[load_step_s];
      div_period <= period_tbl_r[load_step_s];
      div_high   <= high_tbl_r[load_step_s];
      div_load   <= 1'b1;
      div_enable <= 1'b0;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else if (finish_s) begin
      state_r    <= DONE;
      step       <= last_step;
      div_enable <= 1'b0;
      div_load   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b1;
    end else begin
      case (state_r)
        LOAD: begin
          state_r    <= RUN;
          div_load   <= 1'b0;
          div_enable <= 1'b1;
        end
        RUN: begin
          if (div_wrap) begin
            rep_cnt_r <= rep_cnt_r + {{(REP_BITS-1){1'b0}}, 1'b1};
          end else begin
            rep_cnt_r <= rep_cnt_r;
          end
        end
        IDLE, DONE: begin
          state_r <= state_r;
        end
        default: begin
          state_r    <= IDLE;
          div_enable <= 1'b0;
          div_load   <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blink_sequencer.sv
// Self-checking bench for blink_sequencer: expected div_load events are queued
// as stimulus is driven and compared whenever the DUT pulses div_load.
module tb_blink_sequencer;

  logic       clk, rst, start, stop, loop_en, wr_en, div_wrap;
  logic [1:0] last_step, wr_addr, step;
  logic [6:0] wr_period, wr_high, div_period, div_high;
  logic [3:0] wr_reps;
  logic       div_enable, div_load, busy, done;

  typedef struct {
    logic [1:0] stp;
    logic [6:0] per;
    logic [6:0] hi;
  } load_t;

  load_t exp_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;

  blink_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .last_step(last_step), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_period(wr_period), .wr_high(wr_high), .wr_reps(wr_reps),
    .div_wrap(div_wrap), .div_enable(div_enable), .div_load(div_load),
    .div_period(div_period), .div_high(div_high), .step(step),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_load(input logic [1:0] s, input logic [6:0] p, input logic [6:0] h);
    load_t e;
    e.stp = s; e.per = p; e.hi = h;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every div_load pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && div_load) begin
      if (exp_q.size() == 0) begin
        check("unexpected_load", 32'd1, 32'd0);
      end else begin
        load_t e;
        e = exp_q.pop_front();
        check("load_step",   32'(step),       32'(e.stp));
        check("load_period", 32'(div_period), 32'(e.per));
        check("load_high",   32'(div_high),   32'(e.hi));
        check("load_enable", 32'(div_enable), 32'd0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [6:0] p, input logic [6:0] h, input logic [3:0] r);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_period = p; wr_high = h; wr_reps = r;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic wrap();
    @(negedge clk); div_wrap = 1'b1;
    @(negedge clk); div_wrap = 1'b0;
  endtask

  function automatic logic [31:0] outs();
    return {7'd0, div_enable, div_load, div_period, div_high, step, busy, done};
  endfunction

  initial begin
    int exp_step [6] = '{0, 0, 1, 0, 0, 1};
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; wr_en = 1'b0;
    div_wrap = 1'b0; last_step = 2'd1; wr_addr = 2'd0; wr_period = 7'd0;
    wr_high = 7'd0; wr_reps = 4'd0;

    // Reset held 100 ns
    #100;
    check("reset_outs", outs(), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("post_reset_outs", outs(), 32'd0);

    // Single pass
    wr(2'd0, 7'd100, 7'd50, 4'd2);
    wr(2'd1, 7'd20, 7'd10, 4'd1);
    push_load(2'd0, 7'd100, 7'd50);
    pulse_start();
    check("p_load_busy", 32'(busy), 32'd1);
    cyc(1);
    check("p_run_enable", 32'(div_enable), 32'd1);
    push_load(2'd1, 7'd20, 7'd10);
    wrap();
    check("p_rep_step", 32'(step), 32'd0);
    check("p_rep_enable", 32'(div_enable), 32'd1);
    wrap();
    cyc(1);
    check("p_step1", 32'(step), 32'd1);
    wrap();
    check("p_done", 32'(done), 32'd1);
    check("p_done_enable", 32'(div_enable), 32'd0);
    check("p_done_step", 32'(step), 32'd1);
    check("p_done_busy", 32'(busy), 32'd0);

    // Loop over the same table
    loop_en = 1'b1;
    push_load(2'd0, 7'd100, 7'd50);
    pulse_start();
    cyc(1);
    for (int i = 0; i < 6; i++) begin
      check("loop_step", 32'(step), 32'(exp_step[i]));
      check("loop_busy", 32'(busy), 32'd1);
      if (i % 3 == 1) push_load(2'd1, 7'd20, 7'd10);
      if (i % 3 == 2) push_load(2'd0, 7'd100, 7'd50);
      wrap();
      check("loop_busy_w", 32'(busy), 32'd1);
      if (i % 3 != 0) cyc(1);
    end

    // Stop in RUN of step 1
    push_load(2'd1, 7'd20, 7'd10);
    wrap();
    wrap();
    cyc(1);
    check("s_at_step1", 32'(step), 32'd1);
    pulse_stop();
    check("s_enable", 32'(div_enable), 32'd0);
    check("s_step", 32'(step), 32'd0);
    check("s_busy", 32'(busy), 32'd0);
    push_load(2'd0, 7'd100, 7'd50);
    pulse_start();
    cyc(1);
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    check("ss_busy", 32'(busy), 32'd0);
    check("ss_load", 32'(div_load), 32'd0);
    check("ss_enable", 32'(div_enable), 32'd0);

    // reps=0 behaves as one wrap per step; stray wraps ignored
    loop_en = 1'b0;
    wr(2'd0, 7'd30, 7'd15, 4'd0);
    wr(2'd1, 7'd40, 7'd20, 4'd0);
    push_load(2'd0, 7'd30, 7'd15);
    push_load(2'd1, 7'd40, 7'd20);
    pulse_start();
    cyc(1);
    wrap();
    check("r0_step1", 32'(step), 32'd1);
    check("r0_load", 32'(div_load), 32'd1);
    cyc(1);
    wrap();
    check("r0_done", 32'(done), 32'd1);
    wrap();
    check("r0_done_hold", 32'(done), 32'd1);
    check("r0_done_step", 32'(step), 32'd1);
    check("r0_done_load", 32'(div_load), 32'd0);
    pulse_stop();
    wrap();
    check("idle_wrap_busy", 32'(busy), 32'd0);
    check("idle_wrap_done", 32'(done), 32'd0);

    // Table write during RUN of the current step
    loop_en = 1'b1;
    push_load(2'd0, 7'd30, 7'd15);
    push_load(2'd1, 7'd40, 7'd20);
    pulse_start();
    cyc(1);
    wrap();
    cyc(1);
    wr(2'd1, 7'd77, 7'd33, 4'd0);
    check("w_period_held", 32'(div_period), 32'd40);
    check("w_high_held", 32'(div_high), 32'd20);
    push_load(2'd0, 7'd30, 7'd15);
    wrap();
    cyc(1);
    push_load(2'd1, 7'd77, 7'd33);
    wrap();
    check("w_period_new", 32'(div_period), 32'd77);
    pulse_stop();
    cyc(2);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
